// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Also used by the read-side scheduler's round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int RR_MAX        = 32;

  // First set bit after last, wrapping modulo n; returns last if none.
  function automatic int rr_next(
    input logic [RR_MAX-1:0] valid,
    input int                n,
    input int                last
  );
    int pick;
    int idx;
    pick = last;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (valid[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Scans upward from last+1, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [RR_MAX-1:0] vext;

  always_comb begin
    vext = '0;
    vext[NUM_REQ-1:0] = valid;
    idx = IDW'(rr_next(vext, NUM_REQ, int'(last)));
    any = |valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// One bubble cycle separates consecutive grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  MAX_BURST = DEF_MAX_BURST,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [IDW-1:0]           grant_id,
  output logic                     grant_active
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT =
    BW'(MAX_BURST - 1);

  arb_state_t     state;
  arb_state_t     state_n;
  logic [IDW-1:0] grant_n;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] last_n;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic [BW-1:0]  beat_cnt;
  logic [BW-1:0]  beat_n;
  logic           own_valid;
  logic           xfer;
  logic [WIDTH-1:0] slot [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid (req_valid),
    .last  (last_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant_active = (state == ARB_BURST);
  assign own_valid    = req_valid[grant_id];
  assign xfer         = grant_active & own_valid
                      & ~fifo_full;
  assign fifo_wr_en   = xfer;
  assign fifo_data_in = grant_active ?
                        slot[grant_id] : '0;

  always_comb begin
    req_ready = '0;
    if (grant_active && !fifo_full)
      req_ready[grant_id] = 1'b1;
  end

  // A stall (full with valid high) holds state and budget.
  always_comb begin
    state_n = state;
    grant_n = grant_id;
    last_n  = last_grant;
    beat_n  = beat_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_n = ARB_BURST;
          grant_n = pick_idx;
          last_n  = pick_idx;
          beat_n  = '0;
        end
      end
      ARB_BURST: begin
        if (!own_valid) begin
          state_n = ARB_IDLE;
        end else if (xfer) begin
          if (beat_cnt == LAST_BEAT) begin
            state_n = ARB_IDLE;
            beat_n  = '0;
          end else begin
            beat_n = beat_cnt + 1'b1;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_n;
      last_grant <= last_n;
      beat_cnt   <= beat_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with queue-driven
// producers and a behavioural depth-8 FIFO.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [IDW-1:0] grant_id;
  logic           grant_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_total = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_rd[$];
  logic [7:0] fq[$];
  logic [7:0] pq[N][$];
  int         wr_cyc[$];

  bit manual;
  bit use_fifo;
  bit rd_en;
  logic [N-1:0] fire;
  bit           wr_fire;
  logic [7:0]   wr_data;
  logic [N-1:0] pend;
  logic [7:0]   pend_data[N];

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .MAX_BURST (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Producers and FIFO model advance just after each edge.
  initial begin
    logic [7:0] rd;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (fire[i] && pq[i].size() > 0)
          void'(pq[i].pop_front());
      fire = '0;
      if (use_fifo) begin
        if (wr_fire) fq.push_back(wr_data);
        if (rd_en && fq.size() > 0) begin
          rd = fq.pop_front();
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL fifo_read: got 0x%02h, required none",
                     rd);
          end else begin
            e = exp_rd.pop_front();
            if (rd !== e) begin
              errors++;
              $display("FAIL fifo_read: got 0x%02h, required 0x%02h",
                       rd, e);
            end
          end
        end
        fifo_full = (fq.size() >= 8);
      end
      wr_fire = 1'b0;
      if (!manual)
        for (int i = 0; i < N; i++) begin
          req_valid[i] = (pq[i].size() > 0);
          req_data[i*W +: W] =
            (pq[i].size() > 0) ? pq[i][0] : 8'h00;
        end
    end
  end

  // Monitor samples on the falling edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        wr_total++;
        wr_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_order: got 0x%02h, required no write",
                   fifo_data_in);
        end else begin
          e = exp_q.pop_front();
          if (fifo_data_in !== e) begin
            errors++;
            $display("FAIL write_order: got 0x%02h, required 0x%02h",
                     fifo_data_in, e);
          end
        end
        checks++;
        if (fifo_full !== 1'b0) begin
          errors++;
          $display("FAIL write_full: wr_en=1 full=%b, required full=0",
                   fifo_full);
        end
      end
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1 ||
            !req_ready[grant_id]) begin
          errors++;
          $display("FAIL ready_onehot: ready=%b gid=%0d, required one-hot at gid",
                   req_ready, grant_id);
        end
      end
      if (!rst_n || manual) begin
        pend = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (pend[i]) begin
            checks++;
            if (!req_valid[i] ||
                req_data[i*W +: W] !== pend_data[i]) begin
              errors++;
              $display("FAIL producer_hold: p%0d v=%b d=0x%02h, required v=1 d=0x%02h",
                       i, req_valid[i], req_data[i*W +: W],
                       pend_data[i]);
            end
          end
          pend[i] = req_valid[i] & ~req_ready[i];
          pend_data[i] = req_data[i*W +: W];
        end
      end
      fire    = req_valid & req_ready;
      wr_fire = fifo_wr_en;
      wr_data = fifo_data_in;
    end
  end

  task automatic wait_done(input int budget,
                           output int left);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    left = exp_q.size();
    exp_q.delete();
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (wr_total < target && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    fq.delete();
    use_fifo  = 1'b0;
    rd_en     = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int left;
    manual = 1'b1;
    rst_n  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      req_valid = 4'($urandom);
      req_data  = $urandom;
      fifo_full = 1'($urandom);
      #1;
      checks++;
      if (req_ready !== '0 || fifo_wr_en !== 1'b0 ||
          fifo_data_in !== '0 || grant_id !== '0 ||
          grant_active !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b we=%b d=%h gid=%0d ga=%b, required all 0",
                 req_ready, fifo_wr_en, fifo_data_in,
                 grant_id, grant_active);
      end
    end
    fifo_full = 1'b0;
    manual = 1'b0;
    for (int b = 0; b < 4; b++) begin
      pq[0].push_back(8'(8'h01 + b));
      exp_q.push_back(8'(8'h01 + b));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    checks++;
    if (grant_active !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ga=%b we=%b, required 0 0",
               grant_active, fifo_wr_en);
    end
    @(posedge clk);
    #2;
    checks++;
    if (grant_active !== 1'b1 || grant_id !== 2'd0 ||
        fifo_wr_en !== 1'b1 || fifo_data_in !== 8'h01) begin
      errors++;
      $display("FAIL first_grant: ga=%b gid=%0d we=%b d=%h, required 1 0 1 01",
               grant_active, grant_id, fifo_wr_en,
               fifo_data_in);
    end
    wait_done(20, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL reset_burst: %0d pending, required 0",
               left);
    end
    checks++;
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: ga=%b, required 0",
               grant_active);
    end
  endtask

  task automatic test_round_robin();
    int left;
    int base;
    int d;
    int want;
    do_reset();
    base = wr_cyc.size();
    for (int r = 0; r < 2; r++)
      for (int id = 0; id < N; id++)
        for (int b = 0; b < 4; b++)
          exp_q.push_back(8'(id*16 + r*4 + b));
    for (int id = 0; id < N; id++)
      for (int j = 0; j < 8; j++)
        pq[id].push_back(8'(id*16 + j));
    wait_done(120, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL rr_order: %0d pending, required 0",
               left);
    end
    checks++;
    if (wr_cyc.size() < base + 32) begin
      errors++;
      $display("FAIL rr_count: %0d writes, required 32",
               wr_cyc.size() - base);
    end else begin
      for (int k = 1; k < 32; k++) begin
        d = wr_cyc[base+k] - wr_cyc[base+k-1];
        want = (k % 4 == 0) ? 2 : 1;
        checks++;
        if (d != want) begin
          errors++;
          $display("FAIL rr_gap: beat %0d spacing %0d, required %0d",
                   k, d, want);
        end
      end
    end
  endtask

  task automatic test_early_release();
    int left;
    pq[2].push_back(8'hA0);
    pq[2].push_back(8'hA1);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    wait_done(20, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL release_beats: %0d pending, required 0",
               left);
    end
    @(posedge clk);
    #2;
    checks++;
    if (grant_active !== 1'b0 || dut.beat_cnt !== 3'd2) begin
      errors++;
      $display("FAIL release_idle: ga=%b beat=%0d, required 0 2",
               grant_active, dut.beat_cnt);
    end
    pq[0].push_back(8'h0A);
    pq[3].push_back(8'h3A);
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h0A);
    wait_done(20, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL release_next3: %0d pending, required 0",
               left);
    end
    pq[2].push_back(8'hA2);
    pq[2].push_back(8'hA3);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    wait_done(20, left);
    pq[0].push_back(8'h0B);
    pq[1].push_back(8'h1B);
    exp_q.push_back(8'h0B);
    exp_q.push_back(8'h1B);
    wait_done(20, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL release_wrap0: %0d pending, required 0",
               left);
    end
  endtask

  task automatic test_back_pressure();
    int left;
    int base;
    do_reset();
    base = wr_total;
    for (int b = 0; b < 4; b++) begin
      pq[0].push_back(8'(8'hC0 + b));
      exp_q.push_back(8'(8'hC0 + b));
    end
    wait_writes(base + 2);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== '0 || fifo_wr_en !== 1'b0 ||
          dut.beat_cnt !== 3'd2 || grant_active !== 1'b1) begin
        errors++;
        $display("FAIL stall: rdy=%b we=%b beat=%0d ga=%b, required 0 0 2 1",
                 req_ready, fifo_wr_en, dut.beat_cnt,
                 grant_active);
      end
    end
    @(posedge clk);
    #2;
    fifo_full = 1'b0;
    wait_done(20, left);
    checks++;
    if (left != 0 || wr_total - base != 4) begin
      errors++;
      $display("FAIL bp_count: %0d writes %0d pending, required 4 0",
               wr_total - base, left);
    end
  endtask

  task automatic test_reset_mid_burst();
    int left;
    int base;
    do_reset();
    base = wr_total;
    for (int j = 0; j < 8; j++)
      pq[1].push_back(8'(8'h50 + j));
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h51);
    wait_writes(base + 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || fifo_wr_en !== 1'b0 ||
        fifo_data_in !== '0 || grant_id !== '0 ||
        grant_active !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b we=%b d=%h gid=%0d ga=%b, required all 0",
               req_ready, fifo_wr_en, fifo_data_in,
               grant_id, grant_active);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_beats: %0d pending, required 0",
               exp_q.size());
    end
    pq[0].push_back(8'h60);
    exp_q.push_back(8'h60);
    for (int j = 2; j < 8; j++)
      exp_q.push_back(8'(8'h50 + j));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (grant_active !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_priority: ga=%b gid=%0d, required 1 0",
               grant_active, grant_id);
    end
    wait_done(60, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL post_reset: %0d pending, required 0",
               left);
    end
  endtask

  task automatic test_end_to_end();
    int n;
    logic [7:0] seq [9];
    do_reset();
    use_fifo = 1'b1;
    seq = '{8'h70, 8'h71, 8'h72, 8'h90, 8'h91,
            8'h92, 8'hB0, 8'hB1, 8'hB2};
    for (int j = 0; j < 9; j++) begin
      exp_q.push_back(seq[j]);
      exp_rd.push_back(seq[j]);
    end
    for (int j = 0; j < 3; j++) begin
      pq[0].push_back(seq[j]);
      pq[2].push_back(seq[j+3]);
      pq[3].push_back(seq[j+6]);
    end
    n = 0;
    while (fq.size() < 8 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (fq.size() != 8) begin
      errors++;
      $display("FAIL e2e_fill: level %0d, required 8",
               fq.size());
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (fifo_wr_en !== 1'b0 || fifo_full !== 1'b1 ||
          req_ready !== '0) begin
        errors++;
        $display("FAIL e2e_full: we=%b full=%b rdy=%b, required 0 1 0",
                 fifo_wr_en, fifo_full, req_ready);
      end
    end
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL e2e_held: %0d pending, required 1",
               exp_q.size());
    end
    rd_en = 1'b1;
    n = 0;
    while (exp_rd.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    rd_en = 1'b0;
    checks++;
    if (exp_rd.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL e2e_drain: rd %0d wr %0d pending, required 0 0",
               exp_rd.size(), exp_q.size());
    end
    use_fifo = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    manual    = 1'b1;
    use_fifo  = 1'b0;
    rd_en     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fire      = '0;
    pend      = '0;
    wr_fire   = 1'b0;
    wr_data   = '0;
    test_reset();
    test_round_robin();
    test_early_release();
    test_back_pressure();
    test_reset_mid_burst();
    test_end_to_end();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
